// File: rtl/decrypt_pkg.sv
// Shared types and helpers for the decrypt rotate stage.
package decrypt_pkg;

  localparam int unsigned ALPHA_SIZE = 26;
  localparam logic [7:0]  UPPER_BASE = 8'd65;
  localparam logic [7:0]  LOWER_BASE = 8'd97;

  typedef logic [4:0] alpha_idx_t;

  // Stage-1 pipe register contents
  typedef struct packed {
    logic       valid;
    logic       upper;
    logic       lower;
    logic       onehot_ok;
    alpha_idx_t idx;
    logic [7:0] raw;
    alpha_idx_t key;
  } s1_t;

  // (a - b) mod 26 for a, b in 0..25
  function automatic alpha_idx_t alpha_sub(input alpha_idx_t a, input alpha_idx_t b);
    return (a >= b) ? alpha_idx_t'(a - b) : alpha_idx_t'(a + 5'(ALPHA_SIZE) - b);
  endfunction

  // (a + b) mod 26 for a, b in 0..25
  function automatic alpha_idx_t alpha_add(input alpha_idx_t a, input alpha_idx_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'(ALPHA_SIZE)) ? alpha_idx_t'(s - 6'(ALPHA_SIZE)) : s[4:0];
  endfunction

endpackage

// File: rtl/decrypt_onehot_enc.sv
// Combinational 26-bit one-hot to letter index encoder; ok means exactly one bit set.
module decrypt_onehot_enc
  import decrypt_pkg::*;
(
  input  logic [25:0] onehot,
  output alpha_idx_t  idx,
  output logic        ok
);

  // OR-reduce the index of every set bit; only meaningful when ok is high
  always_comb begin
    idx = '0;
    for (int i = 0; i < 26; i++) begin
      if (onehot[i]) idx = idx | alpha_idx_t'(i);
    end
    ok = (onehot != '0) && ((onehot & (onehot - 26'd1)) == '0);
  end

endmodule

// File: rtl/decrypt_pipe_rot.sv
// Decrypt rotate stage: two-stage pipe that rotates a one-hot letter back by the key
// and re-encodes it to ASCII. Optional autokey mode via macro DECRYPT_ROT_AUTOKEY_EN.
module decrypt_pipe_rot
  import decrypt_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [7:0]  ERR_CHAR = 8'h3F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic             is_alpha_upper_case_in,
  input  logic             is_alpha_low_case_in,
  input  logic [31:0]      extended_shift_data_in,
  input  logic             key_load,
  input  logic [4:0]       key_in,
  output logic [7:0]       dout,
  output logic             valid_out,
  output logic             key_err,
  output logic             onehot_err,
  output logic [CNT_W-1:0] char_count
);

  alpha_idx_t       key_q;
  logic             key_err_q;
  logic             key_legal;
  alpha_idx_t       eff_key;
  alpha_idx_t       enc_idx;
  logic             enc_ok;
  s1_t              s1_q;
  logic [7:0]       dout_q;
  logic             valid_q;
  logic             onehot_err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bad;
  alpha_idx_t       rot;
  logic [7:0]       char_d;

  assign key_legal = key_load && (key_in <= 5'd25);

  decrypt_onehot_enc u_enc (
    .onehot (extended_shift_data_in[31:6]),
    .idx    (enc_idx),
    .ok     (enc_ok)
  );

  // Key register and one-cycle error pulse for out-of-range loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q     <= '0;
      key_err_q <= 1'b0;
    end else begin
      if (key_legal) key_q <= key_in;
      key_err_q <= key_load && !key_legal;
    end
  end

`ifdef DECRYPT_ROT_AUTOKEY_EN
  alpha_idx_t offset_q;

  // Running offset: advances per accepted alpha word, cleared by a legal key load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset_q <= '0;
    end else if (key_legal) begin
      offset_q <= '0;
    end else if (en_in && (is_alpha_upper_case_in || is_alpha_low_case_in)) begin
      offset_q <= (offset_q == 5'd25) ? '0 : offset_q + 5'd1;
    end
  end

  assign eff_key = alpha_add(key_q, offset_q);
`else
  assign eff_key = key_q;
`endif

  // Stage 1: capture flags, raw byte, encoded index and the key in force now
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
    end else begin
      s1_q.valid     <= en_in;
      s1_q.upper     <= is_alpha_upper_case_in;
      s1_q.lower     <= is_alpha_low_case_in;
      s1_q.onehot_ok <= enc_ok;
      s1_q.idx       <= enc_idx;
      s1_q.raw       <= extended_shift_data_in[7:0];
      s1_q.key       <= eff_key;
    end
  end

  // Stage 2 decode: rotate alpha, pass raw, flag malformed input
  always_comb begin
    bad = (s1_q.upper && s1_q.lower) ||
          ((s1_q.upper || s1_q.lower) && !s1_q.onehot_ok);
    rot = alpha_sub(s1_q.idx, s1_q.key);
    if (bad)              char_d = ERR_CHAR;
    else if (s1_q.upper)  char_d = UPPER_BASE + {3'b000, rot};
    else if (s1_q.lower)  char_d = LOWER_BASE + {3'b000, rot};
    else                  char_d = s1_q.raw;
  end

  // Stage 2 registers; dout holds while idle, counter saturates at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q       <= '0;
      valid_q      <= 1'b0;
      onehot_err_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= s1_q.valid;
      onehot_err_q <= s1_q.valid && bad;
      if (s1_q.valid) dout_q <= char_d;
      if (s1_q.valid && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign dout       = dout_q;
  assign valid_out  = valid_q;
  assign key_err    = key_err_q;
  assign onehot_err = onehot_err_q;
  assign char_count = cnt_q;

endmodule

// File: tb/tb_decrypt_pipe_rot.sv
// Directed bench for decrypt_pipe_rot. A narrow counter width exposes saturation.
module tb_decrypt_pipe_rot;

  localparam int unsigned TB_CNT_W = 3;
  localparam int          CNT_MAX  = 7;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en_in = 1'b0;
  logic                up_in = 1'b0;
  logic                lo_in = 1'b0;
  logic [31:0]         data_in = '0;
  logic                key_load = 1'b0;
  logic [4:0]          key_in = '0;
  logic [7:0]          dout;
  logic                valid_out;
  logic                key_err;
  logic                onehot_err;
  logic [TB_CNT_W-1:0] char_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  decrypt_pipe_rot #(
    .CNT_W    (TB_CNT_W),
    .ERR_CHAR (8'h3F)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .en_in                  (en_in),
    .is_alpha_upper_case_in (up_in),
    .is_alpha_low_case_in   (lo_in),
    .extended_shift_data_in (data_in),
    .key_load               (key_load),
    .key_in                 (key_in),
    .dout                   (dout),
    .valid_out              (valid_out),
    .key_err                (key_err),
    .onehot_err             (onehot_err),
    .char_count             (char_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_cnt();
    if (exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  task automatic drive(input logic up, input logic lo, input logic [31:0] d);
    en_in   = 1'b1;
    up_in   = up;
    lo_in   = lo;
    data_in = d;
  endtask

  task automatic idle();
    en_in   = 1'b0;
    up_in   = 1'b0;
    lo_in   = 1'b0;
    data_in = '0;
  endtask

  task automatic load_key(input logic [4:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  // Single word through the pipe, checked when it emerges two edges later
  task automatic run_word(input string tag, input logic up, input logic lo,
                          input logic [31:0] d, input logic [7:0] exp_d, input logic exp_err);
    drive(up, lo, d);
    tick();
    idle();
    tick();
    bump_cnt();
    check_eq({tag, "_dout"}, dout, exp_d);
    check_eq({tag, "_valid"}, valid_out, 1'b1);
    check_eq({tag, "_err"}, onehot_err, exp_err);
    check_eq({tag, "_cnt"}, char_count, exp_cnt);
  endtask

  initial begin
    #12;
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_valid", valid_out, 1'b0);
    check_eq("rst_keyerr", key_err, 1'b0);
    check_eq("rst_ohe", onehot_err, 1'b0);
    check_eq("rst_cnt", char_count, 0);
    rst = 1'b1;
    tick();

`ifdef DECRYPT_ROT_AUTOKEY_EN
    load_key(5'd0);
    run_word("ak_b0", 1'b1, 1'b0, 32'h1 << 7, 8'h42, 1'b0);
    run_word("ak_b1", 1'b1, 1'b0, 32'h1 << 7, 8'h41, 1'b0);
    run_word("ak_b2", 1'b1, 1'b0, 32'h1 << 7, 8'h5A, 1'b0);
    load_key(5'd0);
    run_word("ak_rst", 1'b1, 1'b0, 32'h1 << 7, 8'h42, 1'b0);
    run_word("ak_raw", 1'b0, 1'b0, 32'h21, 8'h21, 1'b0);
    run_word("ak_b3", 1'b1, 1'b0, 32'h1 << 7, 8'h41, 1'b0);
`else
    load_key(5'd3);
    check_eq("key3_noerr", key_err, 1'b0);
    run_word("d_key3", 1'b1, 1'b0, 32'h1 << 9, 8'h41, 1'b0);
    tick();
    check_eq("idle_valid", valid_out, 1'b0);
    check_eq("idle_hold", dout, 8'h41);

    load_key(5'd1);
    run_word("a_wrap", 1'b0, 1'b1, 32'h1 << 6, 8'h7A, 1'b0);
    load_key(5'd0);
    run_word("z_key0", 1'b0, 1'b1, 32'h1 << 31, 8'h7A, 1'b0);

    load_key(5'd5);
    run_word("raw21", 1'b0, 1'b0, 32'h21, 8'h21, 1'b0);
    tick();
    tick();
    check_eq("raw_idle_valid", valid_out, 1'b0);
    check_eq("raw_idle_hold", dout, 8'h21);
    check_eq("raw_idle_ohe", onehot_err, 1'b0);

    load_key(5'd3);
    load_key(5'd26);
    check_eq("keyerr_pulse", key_err, 1'b1);
    tick();
    check_eq("keyerr_clear", key_err, 1'b0);
    run_word("d_oldkey", 1'b1, 1'b0, 32'h1 << 9, 8'h41, 1'b0);

    // Key load on the same edge as a word: that word keeps key 3, the next uses 2
    key_load = 1'b1;
    key_in   = 5'd2;
    drive(1'b1, 1'b0, 32'h1 << 9);
    tick();
    key_load = 1'b0;
    drive(1'b1, 1'b0, 32'h1 << 9);
    tick();
    idle();
    bump_cnt();
    check_eq("same_edge_old", dout, 8'h41);
    check_eq("same_edge_old_v", valid_out, 1'b1);
    tick();
    bump_cnt();
    check_eq("same_edge_new", dout, 8'h42);
    check_eq("same_edge_cnt", char_count, exp_cnt);

    run_word("bad_multi", 1'b1, 1'b0, (32'h1 << 6) | (32'h1 << 7), 8'h3F, 1'b1);
    run_word("bad_zero", 1'b1, 1'b0, 32'h21, 8'h3F, 1'b1);
    run_word("bad_both", 1'b1, 1'b1, 32'h1 << 6, 8'h3F, 1'b1);
    check_eq("cnt_sat", char_count, CNT_MAX);
    tick();
    check_eq("ohe_idle", onehot_err, 1'b0);

    // Reset with two words in flight
    drive(1'b1, 1'b0, 32'h1 << 9);
    tick();
    drive(1'b1, 1'b0, 32'h1 << 10);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_dout", dout, 8'h00);
    check_eq("mid_rst_cnt", char_count, 0);
    idle();
    #1 rst = 1'b1;
    exp_cnt = 0;
    tick();
    check_eq("post_rst_v0", valid_out, 1'b0);
    tick();
    check_eq("post_rst_v1", valid_out, 1'b0);
    run_word("key_cleared", 1'b1, 1'b0, 32'h1 << 9, 8'h44, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
